// File: rtl/memory_interface.sv
// Memory interface: MAR/MDR registers plus a three-state access sequencer
// (IDLE -> ACCESS -> DONE) with a wait-cycle timeout and a sticky error flag.
module memory_interface #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] busIn,
   input  logic        ldMAR,
   input  logic        ldMDR,
   input  logic        memEn,
   input  logic        rW,
   input  logic        memReady,
   input  logic [15:0] memRData,
   output logic [15:0] memAddr,
   output logic [15:0] memWData,
   output logic        memReq,
   output logic        memWe,
   output logic [15:0] mdrOut,
   output logic        busy,
   output logic        done,
   output logic        memErr,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Last wait count that may still be followed by another ACCESS cycle.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] mar;
   logic [15:0] mdr;
   logic        op;
   logic [7:0]  wait_cnt;

   assign memAddr   = mar;
   assign memWData  = mdr;
   assign mdrOut    = mdr;
   assign state_dbg = state;

   // Handshake: memReq is held high for every ACCESS cycle with memAddr,
   // memWData and memWe stable; the memory completes the access by raising
   // memReady for one cycle. memReady outside ACCESS carries no meaning.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mar      <= 16'h0000;
         mdr      <= 16'h0000;
         op       <= 1'b0;
         wait_cnt <= 8'h00;
         memErr   <= 1'b0;
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ldMAR) mar <= busIn;
               if (ldMDR) mdr <= busIn;
               if (memEn) begin
                  op       <= rW;
                  memErr   <= 1'b0;
                  wait_cnt <= 8'h00;
                  memReq   <= 1'b1;
                  memWe    <= rW;
                  busy     <= 1'b1;
                  state    <= ACCESS;
               end
            end

            ACCESS: begin
               if (memReady) begin
                  if (!op) mdr <= memRData;
                  memReq <= 1'b0;
                  memWe  <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (wait_cnt == LAST_CNT) begin
                  // Abort: MDR keeps its old value so a failed read is visible.
                  memErr <= 1'b1;
                  memReq <= 1'b0;
                  memWe  <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               memReq <= 1'b0;
               memWe  <= 1'b0;
               done   <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: directed vector table, randomized transactions
// against a transaction-level model, and hand-written reset/sticky sequences.
module tb_memory_interface;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic [15:0] busIn;
   logic        ldMAR;
   logic        ldMDR;
   logic        memEn;
   logic        rW;
   logic        memReady;
   logic [15:0] memRData;
   logic [15:0] memAddr;
   logic [15:0] memWData;
   logic        memReq;
   logic        memWe;
   logic [15:0] mdrOut;
   logic        busy;
   logic        done;
   logic        memErr;
   logic [1:0]  state_dbg;

   memory_interface #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .busIn(busIn), .ldMAR(ldMAR), .ldMDR(ldMDR),
      .memEn(memEn), .rW(rW), .memReady(memReady), .memRData(memRData),
      .memAddr(memAddr), .memWData(memWData), .memReq(memReq), .memWe(memWe),
      .mdrOut(mdrOut), .busy(busy), .done(done), .memErr(memErr),
      .state_dbg(state_dbg)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] mar;
      logic [15:0] mdr;
      logic        rw;
      int          waits;
      logic [15:0] rdata;
      bit          junk;
      bit          simul;
      int          exp_req;
      bit          exp_err;
      logic [15:0] exp_mdr;
   } vec_t;

   int          checks;
   int          failures;
   logic [15:0] model_mdr;
   vec_t        tbl [9];

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // Transaction-level reference: memReady comes after `waits` low cycles.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      r = v;
      r.exp_req = (v.waits < TO) ? v.waits + 1 : TO;
      r.exp_err = (v.waits >= TO);
      if (v.waits < TO && !v.rw) r.exp_mdr = v.rdata;
      else                       r.exp_mdr = v.simul ? model_mdr : v.mdr;
      return r;
   endfunction

   task automatic idle_inputs();
      busIn    = 16'h0000;
      ldMAR    = 1'b0;
      ldMDR    = 1'b0;
      memEn    = 1'b0;
      rW       = 1'b0;
      memReady = 1'b0;
      memRData = 16'h0000;
   endtask

   // Runs one access starting at a negedge in IDLE; ends at a negedge in IDLE.
   task automatic run_vec(input vec_t v);
      logic [15:0] eff_mdr;
      int          n_req;
      int          n_done;
      int          done_at;
      bit          bad;
      eff_mdr = v.simul ? model_mdr : v.mdr;
      if (v.simul) begin
         busIn = v.mar; ldMAR = 1'b1; memEn = 1'b1; rW = v.rw;
         @(negedge clk);
      end else begin
         busIn = v.mar; ldMAR = 1'b1;
         @(negedge clk);
         ldMAR = 1'b0; busIn = v.mdr; ldMDR = 1'b1; memEn = 1'b1; rW = v.rw;
         @(negedge clk);
      end
      n_req = 0; n_done = 0; done_at = -1; bad = 1'b0;
      check("err_clear", {31'd0, memErr}, 32'd0);
      for (int g = 0; g < 64; g++) begin
         if (!busy) bad = 1'b1;
         ldMAR = 1'b0; ldMDR = 1'b0; memEn = 1'b0; rW = 1'b0;
         busIn = 16'($urandom);
         if (memReq) begin
            n_req++;
            if (memAddr !== v.mar || memWData !== eff_mdr || memWe !== v.rw ||
                mdrOut !== eff_mdr) bad = 1'b1;
            memReady = (n_req == v.waits + 1);
            memRData = memReady ? v.rdata : 16'($urandom);
         end else begin
            memReady = 1'($urandom);
            memRData = 16'($urandom);
         end
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = g;
         end
         if (v.junk && (memReq || done)) begin
            ldMAR = 1'b1; ldMDR = 1'b1; busIn = 16'hFFFF; memEn = 1'b1; rW = ~v.rw;
         end
         @(negedge clk);
         if (n_done > 0) break;
      end
      idle_inputs();
      check("req_cycles", n_req, v.exp_req);
      check("done_count", n_done, 32'd1);
      check("done_latency", done_at, v.exp_req);
      check("access_stable", {31'd0, bad}, 32'd0);
      check("done_single", {31'd0, done}, 32'd0);
      check("busy_after", {31'd0, busy}, 32'd0);
      check("req_after", {31'd0, memReq}, 32'd0);
      check("we_after", {31'd0, memWe}, 32'd0);
      check("mdr_after", {16'd0, mdrOut}, {16'd0, v.exp_mdr});
      check("err_after", {31'd0, memErr}, {31'd0, v.exp_err});
      model_mdr = v.exp_mdr;
   endtask

   task automatic run_random(input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.mar   = 16'($urandom);
         v.mdr   = 16'($urandom);
         v.rw    = 1'($urandom);
         v.waits = $urandom_range(0, TO + 2);
         v.rdata = 16'($urandom);
         v.junk  = 1'($urandom);
         v.simul = ($urandom_range(0, 3) == 0);
         v = model(v);
         run_vec(v);
      end
   endtask

   initial begin
      int n;
      checks = 0; failures = 0; model_mdr = 16'h0000;
      idle_inputs();
      rst = 1'b1;
      busIn = 16'hFFFF; ldMAR = 1'b1; ldMDR = 1'b1; memEn = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, memReq}, 32'd0);
      check("rst_we", {31'd0, memWe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, memErr}, 32'd0);
      check("rst_addr", {16'd0, memAddr}, 32'd0);
      check("rst_wdata", {16'd0, memWData}, 32'd0);
      check("rst_mdr", {16'd0, mdrOut}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, 32'd0);
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);

      // mar, mdr, rw, waits, rdata, junk, simul, exp_req, exp_err, exp_mdr
      tbl[0] = '{16'h3000, 16'h5555, 1'b0, 0, 16'hBEEF, 1'b0, 1'b0, 1, 1'b0, 16'hBEEF};
      tbl[1] = '{16'h4001, 16'h1234, 1'b1, 3, 16'hDEAD, 1'b0, 1'b0, 4, 1'b0, 16'h1234};
      tbl[2] = '{16'h0020, 16'h7777, 1'b0, 9, 16'hAAAA, 1'b0, 1'b0, 4, 1'b1, 16'h7777};
      tbl[3] = '{16'h0100, 16'h0F0F, 1'b1, 2, 16'h1357, 1'b1, 1'b0, 3, 1'b0, 16'h0F0F};
      tbl[4] = '{16'h0200, 16'h1111, 1'b0, 1, 16'h2468, 1'b1, 1'b0, 2, 1'b0, 16'h2468};
      tbl[5] = '{16'h00A5, 16'h0000, 1'b0, 0, 16'hC3C3, 1'b0, 1'b1, 1, 1'b0, 16'hC3C3};
      tbl[6] = '{16'h00A6, 16'h0000, 1'b1, 2, 16'h4444, 1'b0, 1'b1, 3, 1'b0, 16'hC3C3};
      tbl[7] = '{16'h0300, 16'hABCD, 1'b1, 4, 16'h5555, 1'b0, 1'b0, 4, 1'b1, 16'hABCD};
      tbl[8] = '{16'h0400, 16'h0001, 1'b0, 3, 16'h9999, 1'b0, 1'b0, 4, 1'b0, 16'h9999};
      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      // memErr must hold through idle cycles until the next accepted memEn.
      run_vec(tbl[2]);
      for (int i = 0; i < 3; i++) begin
         ldMAR = 1'b1; busIn = 16'($urandom); memReady = 1'b1;
         @(negedge clk);
         check("err_sticky", {31'd0, memErr}, 32'd1);
         check("idle_no_req", {31'd0, memReq}, 32'd0);
      end
      idle_inputs();
      @(negedge clk);

      run_random(40);

      // Reset in the second ACCESS cycle aborts the access without a done pulse.
      busIn = 16'h1111; ldMAR = 1'b1;
      @(negedge clk);
      ldMAR = 1'b0; busIn = 16'h2222; ldMDR = 1'b1; memEn = 1'b1; rW = 1'b0;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      check("mid_req_before", {31'd0, memReq}, 32'd1);
      rst = 1'b1; memReady = 1'b1; memRData = 16'h5A5A;
      @(negedge clk);
      check("mid_req", {31'd0, memReq}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_done", {31'd0, done}, 32'd0);
      check("mid_we", {31'd0, memWe}, 32'd0);
      check("mid_addr", {16'd0, memAddr}, 32'd0);
      check("mid_wdata", {16'd0, memWData}, 32'd0);
      check("mid_mdr", {16'd0, mdrOut}, 32'd0);
      check("mid_err", {31'd0, memErr}, 32'd0);
      rst = 1'b0; idle_inputs();
      n = 0;
      for (int i = 0; i < 5; i++) begin
         memReady = 1'($urandom);
         @(negedge clk);
         if (done) n++;
      end
      check("mid_no_done", n, 32'd0);
      model_mdr = 16'h0000;

      run_random(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
- REQ-001 SHALL have parameter TIMEOUT, default 64: maximum ACCESS cycles without memReady before abort (legal range 2..255).
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
- REQ-004 SHALL have port busIn, input, 16: processor bus value, source for MAR/MDR loads.
- REQ-005 SHALL have port ldMAR, input, 1: load MAR from busIn.
- REQ-006 SHALL have port ldMDR, input, 1: load MDR from busIn.
- REQ-007 SHALL have port memEn, input, 1: start a memory access.
- REQ-008 SHALL have port rW, input, 1: access type, 1 = write, 0 = read; sampled with memEn.
- REQ-009 SHALL have port memReady, input, 1: memory completion strobe.
- REQ-010 SHALL have port memRData, input, 16: memory read data, valid when memReady = 1.
- REQ-011 SHALL have port memAddr, output, 16: MAR contents, driven to memory.
- REQ-012 SHALL have port memWData, output, 16: MDR contents, driven to memory.
- REQ-013 SHALL have port memReq, output, 1: access request to memory.
- REQ-014 SHALL have port memWe, output, 1: write enable to memory, qualified by memReq.
- REQ-015 SHALL have port mdrOut, output, 16: MDR contents, feeding the GateMDR 16-bit tri-state bus driver.
- REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.
- REQ-017 SHALL have port done, output, 1: one-cycle completion pulse.
- REQ-018 SHALL have port memErr, output, 1: sticky timeout flag.

Function
- REQ-019 SHALL implement FSM states IDLE, ACCESS, DONE, with state held in registers.
- REQ-020 IDLE: ldMAR=1 loads MAR<=busIn, ldMDR=1 loads MDR<=busIn, both allowed in the same cycle.
- REQ-021 IDLE with memEn=1: latch rW into op register, clear memErr, clear waitCnt, go to ACCESS next cycle.
- REQ-022 Loads and memEn in the same IDLE cycle SHALL take effect together; the access SHALL use the newly loaded MAR/MDR.
- REQ-023 ACCESS: memReq=1, memWe=op, memAddr=MAR, memWData=MDR, all stable for the whole state.
- REQ-024 ACCESS with memReady=1: on a read, MDR<=memRData; go to DONE. Minimum latency is memEn edge to done = 2 cycles.
- REQ-025 ACCESS with memReady=0: increment waitCnt (8-bit).
- REQ-026 When waitCnt = TIMEOUT-1 and memReady=0: set memErr=1, leave MDR unchanged, go to DONE.
- REQ-027 DONE: memReq=0, done=1 for exactly one cycle, unconditionally return to IDLE.
- REQ-028 ldMAR, ldMDR and memEn SHALL be ignored in ACCESS and DONE; there is no queuing.
- REQ-029 memReady outside ACCESS SHALL be ignored.
- REQ-030 mdrOut SHALL equal MDR at all times, with no tri-state inside this block.
- REQ-031 memErr SHALL stay set until the next accepted memEn or rst.

Reset
- REQ-032 rst=1 SHALL force state IDLE and clear MAR, MDR, op, waitCnt and memErr to 0 at the next edge, overriding all other inputs.
- REQ-033 Reset values: memReq=0, memWe=0, busy=0, done=0, memErr=0, memAddr=16'h0000, memWData=16'h0000, mdrOut=16'h0000.
- REQ-034 rst asserted during ACCESS SHALL abort the access: memReq=0 the cycle after rst is sampled, no done pulse, MDR=0.

Verification
- REQ-035 Read: busIn=16'h3000 with ldMAR, then memEn with rW=0, memReady=1 in the first ACCESS cycle with memRData=16'hBEEF -> memReq high 1 cycle, memAddr=16'h3000, done 2 cycles after memEn, mdrOut=16'hBEEF.
- REQ-036 Write with wait: MAR=16'h4001, MDR=16'h1234, memEn with rW=1, memReady after 3 low cycles -> memWe=1, memWData=16'h1234 for 4 cycles, done once, MDR unchanged.
- REQ-037 Timeout: TIMEOUT=4, memReady held 0 -> memReq high 4 cycles, memErr=1, done pulse; memErr clears on the next memEn.
- REQ-038 Busy-ignore: ldMDR with busIn=16'hFFFF and memEn during ACCESS -> MDR unchanged, exactly one access completes.
- REQ-039 Simultaneous: ldMAR (busIn=16'h00A5) and memEn in the same IDLE cycle -> memAddr=16'h00A5 in ACCESS.
- REQ-040 Mid-access reset: rst in the second ACCESS cycle -> memReq=0 next cycle, busy=0, all outputs at reset values, done never asserted.
